// File: rtl/fir_out_collector.sv
// fir_out_collector: buffers FIR engine stream results in a FIFO, drained by the CPU over Wishbone,
// with a done interrupt, beat counter and checksum.
module fir_out_collector #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [pDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]          occ_q, occ_d;
    logic [pCNT_WIDTH-1:0]  total_q, total_d;
    logic [31:0]            sum_q, sum_d, dat_q, dat_d, status, rdata;
    logic                   enable_q, enable_d, irq_en_q, irq_en_d, done_q, done_d;
    logic                   underflow_q, underflow_d, ack_q, ack_d, irq_q, irq_d;
    logic                   full, empty, req, wr_ctrl, clr, rd_data, pop, accept, push;
    logic                   unused;

    assign unused = ^{wbs_sel_i[3:1], wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:3]};

    always_comb begin
        full        = occ_q == OW'(DEPTH);
        empty       = occ_q == '0;
        s_tready    = enable_q & ~full & ~done_q;
        req         = wbs_stb_i & wbs_cyc_i & ~ack_q;
        wr_ctrl     = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
        clr         = wr_ctrl & wbs_dat_i[1];
        rd_data     = req & ~wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
        pop         = rd_data & ~empty;
        accept      = s_tvalid & s_tready;
        // a clear on the same edge discards the incoming beat
        push        = accept & ~clr;
        wr_ptr_d    = clr ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d    = clr ? '0 : rd_ptr_q + AW'(pop);
        occ_d       = clr ? '0 : occ_q + OW'(push) - OW'(pop);
        total_d     = clr ? '0 : (accept & ~&total_q) ? total_q + pCNT_WIDTH'(1) : total_q;
        sum_d       = clr ? '0 : accept ? sum_q + 32'(s_tdata) : sum_q;
        done_d      = ~clr & (done_q | (accept & s_tlast));
        underflow_d = ~clr & (underflow_q | (rd_data & empty));
        enable_d    = wr_ctrl ? wbs_dat_i[0] : enable_q;
        irq_en_d    = wr_ctrl ? wbs_dat_i[2] : irq_en_q;
        irq_d       = done_q & irq_en_q;
        ack_d       = req;
        status      = {16'(occ_q), 4'b0, underflow_q, full, empty, done_q, 5'b0, irq_en_q, 1'b0, enable_q};
        rdata       = wbs_adr_i[3:2] == 2'd0 ? status :
                      wbs_adr_i[3:2] == 2'd1 ? (empty ? '0 : 32'(mem_q[rd_ptr_q])) :
                      wbs_adr_i[3:2] == 2'd2 ? 32'(total_q) : sum_q;
        dat_d       = ~req ? dat_q : wbs_we_i ? '0 : rdata;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= s_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            total_q     <= '0;
            sum_q       <= '0;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            total_q     <= total_d;
            sum_q       <= sum_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_fir_out_collector.sv
// tb_fir_out_collector: randomized stream/Wishbone traffic against a queue-based model;
// register reads are scored by a monitor that pops expected values on each ack.
module tb_fir_out_collector;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [31:0] s_tdata = '0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0, wbs_ack_o, irq_o;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o;

    always #5 clk = ~clk;

    fir_out_collector #(.pDATA_WIDTH(32), .DEPTH(DEPTH), .pCNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(s_tready), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
    );

    typedef struct {logic [31:0] d; bit l;} beat_t;
    typedef struct {bit chk; logic [31:0] v; string n;} exp_t;

    beat_t       src[$];
    exp_t        expq[$];
    exp_t        mon_e;
    logic [31:0] mq[$];
    int          tests = 0, fails = 0;
    bit          m_en, m_ie, m_done, m_uf, m_irq, last_acc;
    logic [15:0] m_total;
    logic [31:0] m_sum;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic bit m_ready();
        return m_en && mq.size() < DEPTH && !m_done;
    endfunction

    function automatic logic [31:0] m_status();
        return {16'(mq.size()), 4'b0, m_uf, mq.size() == DEPTH, mq.size() == 0, m_done,
                5'b0, m_ie, 1'b0, m_en};
    endfunction

    function automatic void model_reset();
        mq.delete();
        {m_en, m_ie, m_done, m_uf, m_irq} = '0;
        m_total = '0;
        m_sum = '0;
    endfunction

    // effects of one clock edge, computed from the register map rules
    function automatic void model_edge(bit v, logic [31:0] d, bit l, bit req, bit we,
                                       logic [1:0] a, logic [31:0] wd);
        bit acc = v && m_ready();
        bit clr = req && we && a == 2'd0 && wd[1];
        exp_t e;
        last_acc = acc;
        if (req) begin
            e.chk = !we;
            e.n = a == 2'd0 ? "STATUS" : a == 2'd1 ? "DATA" : a == 2'd2 ? "TOTAL" : "SUM";
            e.v = a == 2'd0 ? m_status() : a == 2'd1 ? (mq.size() != 0 ? mq[0] : 32'h0) :
                  a == 2'd2 ? 32'(m_total) : m_sum;
            expq.push_back(e);
        end
        m_irq = m_done && m_ie;
        if (clr) begin
            mq.delete();
            m_total = '0;
            m_sum = '0;
            m_done = 0;
            m_uf = 0;
        end else begin
            if (req && !we && a == 2'd1) begin
                if (mq.size() != 0) void'(mq.pop_front());
                else m_uf = 1;
            end
            if (acc) begin
                mq.push_back(d);
                if (m_total != 16'hFFFF) m_total++;
                m_sum += d;
                if (l) m_done = 1;
            end
        end
        if (req && we && a == 2'd0) begin
            m_en = wd[0];
            m_ie = wd[2];
        end
    endfunction

    task automatic tick(input bit v, input logic [31:0] d, input bit l, input bit req,
                        input bit we, input logic [1:0] a, input logic [31:0] wd);
        s_tvalid = v; s_tdata = d; s_tlast = l;
        wbs_stb_i = req; wbs_cyc_i = req; wbs_we_i = we;
        wbs_adr_i = {28'h0, a, 2'b00}; wbs_dat_i = wd;
        @(negedge clk);
        last_acc = 0;
        if (!rst) begin
            check("s_tready", s_tready, m_ready());
            check("irq_o", irq_o, m_irq);
            model_edge(v, d, l, req, we, a, wd);
        end
        @(posedge clk); #1;
        if (rst) model_reset();
    endtask

    task automatic step(input bit fv, input bit req, input bit we, input logic [1:0] a,
                        input logic [31:0] wd);
        bit v;
        beat_t b;
        v = src.size() > 0 && (fv || $urandom_range(0, 3) != 0);
        b.d = $urandom;
        b.l = 0;
        if (v) b = src[0];
        tick(v, b.d, b.l, req, we, a, wd);
        if (v && last_acc) void'(src.pop_front());
    endtask

    task automatic rd(input logic [1:0] a);
        step(0, 1, 0, a, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic run(input int n, input bit rdq);
        for (int i = 0; i < n; i++)
            step(0, rdq && i % 2 == 0 && i < n - 1, 0, 2'd1, 0);
    endtask

    task automatic reset_checks();
        s_tvalid = 0; wbs_stb_i = 0; wbs_cyc_i = 0;
        @(negedge clk);
        check("rst_tready", s_tready, 0);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_dat", wbs_dat_o, 0);
        check("rst_irq", irq_o, 0);
        @(posedge clk); #1;
    endtask

    task automatic add_beats(input int n, input bit rnd, input bit last);
        beat_t b;
        for (int i = 1; i <= n; i++) begin
            b.d = rnd ? $urandom : 32'(i);
            b.l = last && i == n;
            src.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wbs_ack_o) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stray_ack: got ack expected no ack");
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.chk) check(mon_e.n, wbs_dat_o, mon_e.v);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        beat_t b;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        reset_checks();
        // in-order readout after a tlast-terminated run
        wr(0, 32'h1);
        add_beats(5, 0, 1);
        run(30, 0);
        rd(0); rd(2); rd(3);
        repeat (5) rd(1);
        rd(0);
        // fill to full, then one pop lets the next beat in
        wr(0, 32'h3);
        add_beats(20, 1, 0);
        run(40, 0);
        rd(0);
        rd(1);
        run(6, 0);
        rd(0);
        run(60, 1);
        // concurrent stream and reads across pointer wrap, plus a forced push+pop edge
        add_beats(40, 1, 0);
        run(80, 1);
        step(1, 1, 0, 2'd1, 0);
        step(0, 0, 0, 0, 0);
        rd(0);
        run(60, 1);
        // underflow and its clear
        rd(1); rd(0);
        wr(0, 32'h3);
        rd(0);
        // interrupt and clear preserving enable
        wr(0, 32'h5);
        add_beats(3, 0, 1);
        run(20, 0);
        rd(0);
        wr(0, 32'h7);
        run(4, 0);
        rd(0); rd(2);
        // checksum wrap-around, then reset mid-stream
        wr(0, 32'h3);
        b.d = 32'hFFFF_FFFF; b.l = 0; src.push_back(b);
        b.d = 32'h2; src.push_back(b);
        run(12, 0);
        rd(3);
        add_beats(10, 1, 0);
        run(4, 0);
        rst = 1;
        step(1, 0, 0, 0, 0);
        rst = 0;
        src.delete();
        reset_checks();
        rd(0); rd(2); rd(3);
        run(4, 0);
        check("pending_acks", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_out_collector.md
Name: fir_out_collector

Overview:
Downstream stage of the FIR/matrix-multiply engine. Accepts the engine's AXI-Stream result output into a small FIFO and asserts backpressure when full. The CPU drains results over a Wishbone slave. A done flag/interrupt is raised on tlast, and the block keeps a running word count and a 32-bit checksum for self-test.

Parameters:
pDATA_WIDTH, 32, stream/Wishbone data width
DEPTH, 16, FIFO depth in words; power of two, 2..256
pCNT_WIDTH, 16, width of the total-received counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_tvalid  in  1  result beat valid (from engine sm_tvalid)
s_tdata  in  pDATA_WIDTH  result data
s_tlast  in  1  last result of the run
s_tready  out  1  collector can accept the beat
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  1 = write, 0 = read
wbs_sel_i  in  4  byte enables; writes honour only sel[0] for CTRL
wbs_adr_i  in  32  byte address; only bits [3:2] are decoded
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  transfer acknowledge
wbs_dat_o  out  32  read data
irq_o  out  1  done interrupt

Behaviour:
- Reset values:
  - s_tready=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - FIFO empty; count=0, total=0, sum=0.
  - enable=0, irq_en=0, done=0, underflow=0.
- Register map, selected by adr[3:2]:
  - 0 CTRL/STATUS
    - Write: bit0 enable (RW); bit1 clear (write-1 pulse, reads 0); bit2 irq_en (RW).
    - Read: bits 0 and 2 as written; bit8 done; bit9 empty; bit10 full; bit11 underflow; [31:16] FIFO occupancy.
  - 1 DATA: a read pops the FIFO head. Writes are ignored but still acked.
  - 2 TOTAL: [pCNT_WIDTH-1:0] number of beats accepted since the last clear. Saturates at all-ones. Read-only.
  - 3 SUM: 32-bit wrap-around sum of all accepted beats since the last clear. Read-only.
- Wishbone:
  - A request is stb&cyc&!ack. ack_o is registered: high exactly one cycle, the cycle after the request.
  - wbs_dat_o is registered in the same edge as ack. Minimum spacing is one request per two cycles.
  - All side effects (writes, pops) happen on the edge that raises ack.
- Stream accept:
  - s_tready = enable & !full & !done, combinational from registered state only.
  - A beat is accepted when s_tvalid & s_tready. On accept: push s_tdata, total+=1, sum+=s_tdata.
  - If s_tlast is set on the accepted beat, done<=1, so s_tready drops the next cycle.
- Pop:
  - DATA read with occupancy>0: dat_o = head, occupancy decrements.
  - DATA read with occupancy==0: dat_o=0, no pointer change, underflow<=1 (sticky).
- Simultaneous push and pop in the same cycle: both take effect and occupancy is unchanged. A push into a full FIFO cannot occur because tready is low.
- Pointers wrap modulo DEPTH. Occupancy is $clog2(DEPTH)+1 bits wide, so full equals occupancy==DEPTH.
- Clear:
  - Empties the FIFO and zeroes total, sum, done and underflow on the ack edge. enable and irq_en are preserved.
  - A stream beat accepted on the same edge is discarded (clear wins).
  - A pop on the same edge is impossible, since only one Wishbone request is active at a time.
- irq_o = done & irq_en, registered. It stays high until clear or until irq_en is written 0.
- Disabling (enable=0) mid-run only stalls s_tready. FIFO contents, count and sum are retained.
- rst mid-run returns every register to its reset value on the next edge, regardless of traffic.

Test Plan:
1. Reset, then write CTRL=0x1 and stream 5 beats 1..5 with tlast on the 5th. Expect STATUS done=1 and occupancy=5, TOTAL=5, SUM=15. Five DATA reads return 1,2,3,4,5. Then empty=1.
2. DEPTH=16: stream 20 beats with no reads. Expect s_tready to drop after the 16th accept and full=1. One DATA read returns beat 1, after which the 17th beat is accepted on the following cycles.
3. Sustained streaming while the CPU reads continuously. Hit a push and pop on the same edge; occupancy must be unchanged. Data order must be preserved across pointer wrap, checked over 40 beats.
4. Read DATA while empty. Expect dat_o=0 and underflow=1, with occupancy still 0. Then clear: underflow=0.
5. Write CTRL=0x5, then stream 3 beats with tlast. Expect irq_o=1 one cycle after done. Write CTRL=0x7 (clear): irq_o=0, done=0, TOTAL=0, and enable still reads 1.
6. Stream beats 0xFFFFFFFF and 0x2. Expect SUM=0x00000001 (wrap-around). Assert rst mid-stream: all outputs read back at their reset values.
